// File: rtl/vec_acc_int.sv
// Block accumulator for adder-tree sums: IDLE/ACC/OUT FSM with zero-bubble block chaining.
// Define VEC_ACC_INT_SAT_EN to clamp on signed overflow instead of wrapping.
module vec_acc_int #(
    parameter int bit_width = 16,
    parameter int length    = 32,
    parameter int sum_width = bit_width + $clog2(length),
    parameter int acc_width = 32,
    parameter int cnt_width = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic signed [sum_width-1:0] i_sum,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic        [cnt_width-1:0] i_beats,
    output logic signed [acc_width-1:0] o_acc,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_ovf
);

    if (acc_width < sum_width) begin : g_width_check
        $error("vec_acc_int: acc_width must be >= sum_width");
    end

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    localparam logic [cnt_width-1:0] ONE = cnt_width'(1);
    localparam logic signed [acc_width-1:0] MAX = {1'b0, {(acc_width-1){1'b1}}};
    localparam logic signed [acc_width-1:0] MIN = {1'b1, {(acc_width-1){1'b0}}};

    state_t                      state;
    logic        [cnt_width-1:0] remaining;
    logic signed [acc_width-1:0] ext;
    logic signed [acc_width-1:0] sum;
    logic signed [acc_width-1:0] nxt;
    logic                        ovf;
    logic                        accept;

    // In OUT a beat can only be taken alongside the result handshake.
    assign o_ready = !i_rst && (state != OUT || i_ready);
    assign accept  = i_valid && o_ready;

    assign ext = acc_width'(i_sum);
    assign sum = o_acc + ext;
    assign ovf = (o_acc[acc_width-1] == ext[acc_width-1]) &&
                 (sum[acc_width-1] != o_acc[acc_width-1]);

`ifdef VEC_ACC_INT_SAT_EN
    assign nxt = ovf ? (o_acc[acc_width-1] ? MIN : MAX) : sum;
`else
    assign nxt = sum;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            o_acc     <= '0;
            o_valid   <= 1'b0;
            o_ovf     <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE, OUT: begin
                    if (accept) begin
                        o_acc <= ext;
                        o_ovf <= 1'b0;
                        // A beat count of zero is handled as a single-beat block.
                        if (i_beats <= ONE) begin
                            remaining <= '0;
                            state     <= OUT;
                            o_valid   <= 1'b1;
                        end else begin
                            remaining <= i_beats - ONE;
                            state     <= ACC;
                            o_valid   <= 1'b0;
                        end
                    end else if (state == OUT && i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                    end
                end
                ACC: begin
                    if (accept) begin
                        o_acc     <= nxt;
                        o_ovf     <= o_ovf | ovf;
                        remaining <= remaining - ONE;
                        if (remaining == ONE) begin
                            state   <= OUT;
                            o_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_acc_int.sv
// Bench for vec_acc_int at acc_width=24: transaction-level model, per-cycle protocol checks, directed literals.
module tb_vec_acc_int;

    localparam int BW = 16;
    localparam int LEN = 32;
    localparam int SW = BW + $clog2(LEN);
    localparam int AW = 24;
    localparam int CW = 8;
    localparam longint AMAX = (64'sd1 <<< (AW-1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (AW-1));
    localparam longint AMOD = 64'sd1 <<< AW;

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic signed [SW-1:0] i_sum = '0;
    logic                 i_valid = 1'b0;
    logic                 o_ready;
    logic        [CW-1:0] i_beats = '0;
    logic signed [AW-1:0] o_acc;
    logic                 o_valid;
    logic                 i_ready = 1'b1;
    logic                 o_ovf;

    vec_acc_int #(.bit_width(BW), .length(LEN), .acc_width(AW), .cnt_width(CW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_sum(i_sum), .i_valid(i_valid), .o_ready(o_ready),
        .i_beats(i_beats), .o_acc(o_acc), .o_valid(o_valid), .i_ready(i_ready), .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;
    bit rand_rdy = 1'b0;

    longint exp_acc[$];
    bit     exp_ovf[$];
    longint got_acc[$];
    bit     got_ovf[$];

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: per-block running sum in 64-bit arithmetic, wrapped or clamped to acc_width.
    longint m_acc = 0;
    bit     m_ovf = 1'b0;
    int     m_left = 0;
    bit     p_last = 1'b0, p_valid = 1'b0, p_rdy = 1'b0, p_ovf = 1'b0;
    longint p_acc = 0;

    always @(negedge i_clk) begin
        longint e, s;
        bit last;
        if (i_rst) begin
            chk("rst_o_acc", longint'(o_acc), 0);
            chk("rst_o_valid", longint'(o_valid), 0);
            chk("rst_o_ovf", longint'(o_ovf), 0);
            chk("rst_o_ready", longint'(o_ready), 0);
            m_left = 0;
            exp_acc.delete();
            exp_ovf.delete();
            p_last = 0; p_valid = 0; p_rdy = 0;
        end else begin
            last = 1'b0;
            chk("o_ready_rule", longint'(o_ready), longint'(!o_valid || i_ready));
            chk("o_valid_timing", longint'(o_valid), longint'(p_last || (p_valid && !p_rdy)));
            if (p_valid && !p_rdy) begin
                chk("hold_o_acc", longint'(o_acc), p_acc);
                chk("hold_o_ovf", longint'(o_ovf), longint'(p_ovf));
            end
            if (o_valid && i_ready) begin
                got_acc.push_back(longint'(o_acc));
                got_ovf.push_back(o_ovf);
                if (exp_acc.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("result_acc", longint'(o_acc), exp_acc.pop_front());
                    chk("result_ovf", longint'(o_ovf), longint'(exp_ovf.pop_front()));
                end
            end
            if (i_valid && o_ready) begin
                e = longint'(i_sum);
                if (m_left == 0) begin
                    m_left = (i_beats == 0) ? 1 : int'(i_beats);
                    m_acc = e;
                    m_ovf = 1'b0;
                end else begin
                    s = m_acc + e;
                    if (s > AMAX || s < AMIN) begin
                        m_ovf = 1'b1;
`ifdef VEC_ACC_INT_SAT_EN
                        s = (s > AMAX) ? AMAX : AMIN;
`else
                        s = (s > AMAX) ? s - AMOD : s + AMOD;
`endif
                    end
                    m_acc = s;
                end
                m_left--;
                if (m_left == 0) begin
                    exp_acc.push_back(m_acc);
                    exp_ovf.push_back(m_ovf);
                    last = 1'b1;
                end
            end
            p_last = last; p_valid = o_valid; p_rdy = i_ready;
            p_acc = longint'(o_acc); p_ovf = o_ovf;
        end
    end

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input longint s, input int b);
        bit ok = 1'b0;
        i_valid = 1'b1;
        i_sum   = SW'(s);
        i_beats = CW'(b);
        for (int t = 0; t < 200; t++) begin
            @(negedge i_clk);
            if (o_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic wait_got(input int n);
        for (int t = 0; t < 100 && got_acc.size() < n; t++) @(posedge i_clk);
        #1;
        if (got_acc.size() < n) chk("result_timeout", longint'(got_acc.size()), longint'(n));
    endtask

    function automatic longint got_at(input int i);
        return (i < got_acc.size()) ? got_acc[i] : 64'sh7fff_ffff_ffff;
    endfunction

    initial begin
        cyc(3);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("ready_after_reset", longint'(o_ready), 1);
        @(posedge i_clk); #1;

        // 4-beat block
        got_acc.delete(); got_ovf.delete();
        send(100, 4); send(-20, 0); send(7, 9); send(1, 0);
        wait_got(1);
        chk("blk4_acc", got_at(0), 88);
        if (got_ovf.size() > 0) chk("blk4_ovf", longint'(got_ovf[0]), 0);

        // zero and one beat counts
        got_acc.delete(); got_ovf.delete();
        send(-5, 0); send(12, 1);
        wait_got(2);
        chk("single_a", got_at(0), -5);
        chk("single_b", got_at(1), 12);
        cyc(2);

        // back-pressure then same-cycle handshake and new block
        got_acc.delete(); got_ovf.delete();
        i_ready = 1'b0;
        send(3, 2); send(4, 0);
        repeat (3) begin
            @(negedge i_clk);
            chk("bp_o_valid", longint'(o_valid), 1);
            chk("bp_o_acc", longint'(o_acc), 7);
            chk("bp_o_ready", longint'(o_ready), 0);
        end
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        send(9, 1);
        wait_got(2);
        chk("bp_first", got_at(0), 7);
        chk("bp_second", got_at(1), 9);
        cyc(2);

        // overflow at 24 bits
        got_acc.delete(); got_ovf.delete();
        for (int k = 0; k < 9; k++) send(1048575, 9);
        wait_got(1);
`ifdef VEC_ACC_INT_SAT_EN
        chk("ovf_acc", got_at(0), 8388607);
`else
        chk("ovf_acc", got_at(0), -7340041);
`endif
        if (got_ovf.size() > 0) chk("ovf_flag", longint'(got_ovf[0]), 1);
        cyc(2);

        // reset mid-block
        got_acc.delete(); got_ovf.delete();
        send(10, 4); send(20, 0);
        i_rst = 1'b1;
        #1;
        chk("midrst_o_acc", longint'(o_acc), 0);
        chk("midrst_o_valid", longint'(o_valid), 0);
        chk("midrst_o_ready", longint'(o_ready), 0);
        cyc(2);
        i_rst = 1'b0;
        send(3, 2); send(4, 0);
        wait_got(1);
        chk("after_rst_acc", got_at(0), 7);
        chk("after_rst_count", longint'(got_acc.size()), 1);

        // randomized blocks with random back-pressure and gaps
        rand_rdy = 1'b1;
        for (int blk = 0; blk < 60; blk++) begin
            int b, n;
            bit big;
            b = $urandom_range(0, 12);
            n = (b == 0) ? 1 : b;
            big = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < n; k++) begin
                longint s;
                if (big) s = ($urandom_range(0, 1) != 0) ? 1048575 - $urandom_range(0, 15)
                                                         : -1048576 + $urandom_range(0, 15);
                else     s = longint'($urandom_range(0, 2097151)) - 1048576;
                send(s, (k == 0) ? b : $urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) cyc($urandom_range(1, 2));
            end
        end
        rand_rdy = 1'b0;
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        for (int t = 0; t < 100 && exp_acc.size() > 0; t++) @(posedge i_clk);
        @(negedge i_clk);
        chk("drain", longint'(exp_acc.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vec_acc_int.md
VEC_ACC_INT -- requirements
Module: vec_acc_int

Interface
REQ-001 SHALL have parameter bit_width, 16, element width of the upstream adder-tree input vector.
REQ-002 SHALL have parameter length, 32, element count of the upstream adder-tree input vector.
REQ-003 SHALL have parameter sum_width, bit_width+$clog2(length), width of each incoming tree sum.
REQ-004 SHALL have parameter acc_width, 32, accumulator and result width; acc_width < sum_width SHALL fail elaboration.
REQ-005 SHALL have parameter cnt_width, 8, width of the beats-per-block field.
REQ-006 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port i_sum  input  signed sum_width  adder-tree sum for one beat.
REQ-009 SHALL have port i_valid  input  1  i_sum (and i_beats) valid.
REQ-010 SHALL have port o_ready  output  1  block accepts a beat this cycle.
REQ-011 SHALL have port i_beats  input  cnt_width  beats in the block; sampled only on a block's first beat.
REQ-012 SHALL have port o_acc  output  signed acc_width  block accumulation result.
REQ-013 SHALL have port o_valid  output  1  o_acc holds a completed block result.
REQ-014 SHALL have port i_ready  input  1  downstream accepts o_acc.
REQ-015 SHALL have port o_ovf  output  1  sticky signed overflow flag for the current block.

Function
REQ-016 SHALL accept a beat when i_valid && o_ready in the same cycle; an output handshake is o_valid && i_ready.
REQ-017 SHALL implement FSM states IDLE, ACC and OUT.
REQ-018 In IDLE, o_ready=1 and o_valid=0; an accepted beat loads acc=sext(i_sum), clears o_ovf and loads remaining=max(i_beats,1)-1; the next state is OUT if remaining==0, else ACC.
REQ-019 In ACC, o_ready=1; an accepted beat sets acc+=sext(i_sum) and decrements remaining; after the beat taking remaining to 0, the next state is OUT.
REQ-020 In OUT, o_valid=1 and o_ready=i_ready; o_acc and o_ovf SHALL hold stable while i_ready=0.
REQ-021 Output handshake in OUT without an accepted beat: the next state is IDLE.
REQ-022 Output handshake in OUT with an accepted beat in the same cycle: the beat is treated as the first beat of a new block per REQ-018, giving zero bubble between blocks.
REQ-023 Latency: o_valid SHALL assert in the cycle after the block's last beat is accepted.
REQ-024 i_beats=0 SHALL be treated as 1.
REQ-025 i_beats SHALL be ignored on non-first beats.
REQ-026 Addition SHALL be performed at acc_width.
REQ-027 Overflow SHALL be flagged on an add when both operands have the same sign and the result sign differs; o_ovf then sets and stays set until the next block's first beat.
REQ-028 o_acc SHALL be the accumulator register and retains the last result in IDLE.
REQ-029 i_valid=0 in ACC SHALL stall the block indefinitely without a state change.

Reset
REQ-030 While i_rst=1, the FSM SHALL be forced to IDLE and o_acc=0, o_valid=0, o_ovf=0, remaining=0, o_ready=0.
REQ-031 After i_rst deasserts, o_ready SHALL assert (IDLE) in the first clock cycle.
REQ-032 Reset mid-block SHALL discard the partial accumulation; the first beat after reset starts a new block.

Configuration
REQ-033 Macro VEC_ACC_INT_SAT_EN SHALL select overflow behaviour.
REQ-034 Without VEC_ACC_INT_SAT_EN, overflowing adds SHALL wrap modulo 2^acc_width and set o_ovf.
REQ-035 With VEC_ACC_INT_SAT_EN, overflowing adds SHALL clamp to 2^(acc_width-1)-1 or -2^(acc_width-1), set o_ovf, and continue accumulating from the clamped value.

Verification
REQ-036 i_beats=4, sums 100,-20,7,1 back-to-back, i_ready=1 -> o_valid=1 for one cycle, one cycle after the 4th accept; o_acc=88, o_ovf=0.
REQ-037 i_beats=0, sum -5; then i_beats=1, sum 12 -> two single-beat blocks, o_acc=-5 then 12.
REQ-038 Block i_beats=2, sums 3,4; i_ready=0 for 3 cycles -> o_acc=7 held, o_ready=0; then i_ready=1 with i_valid=1, sum 9, i_beats=1 -> handshake and new-block accept in the same cycle; next result o_acc=9.
REQ-039 acc_width=24, i_beats=9, each sum 1048575 -> without VEC_ACC_INT_SAT_EN o_acc=-7340041, o_ovf=1; with VEC_ACC_INT_SAT_EN o_acc=8388607, o_ovf=1.
REQ-040 i_beats=4; assert i_rst after 2 beats (10,20) -> o_acc=0, o_valid=0, o_ready=0 immediately; after release, block i_beats=2, sums 3,4 -> o_acc=7.
